// File: rtl/inst_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_if
// Groups the controller handshake and the instruction-ROM port of the fetch
// stage into one bundle.
//   master : controller/ROM side (drives fetch_req, pc_load, pc_target,
//            rom_data; observes everything else)
//   slave  : the fetch unit itself
// Signals:
//   fetch_req  - controller asks for the next instruction
//   pc_load    - redirect the PC to pc_target
//   pc_target  - redirect word address (6 bits)
//   rom_en     - ROM read enable
//   rom_addr   - ROM word address
//   rom_data   - ROM read data (32 bits)
//   Inst       - instruction register
//   Inst_Addr  - current PC (address of the next fetch)
//   fetch_done - one-cycle completion pulse
//   busy       - fetch unit is not idle
// ---------------------------------------------------------------------------
interface inst_fetch_unit_if;
    logic        fetch_req;
    logic        pc_load;
    logic [5:0]  pc_target;
    logic        rom_en;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] Inst;
    logic [5:0]  Inst_Addr;
    logic        fetch_done;
    logic        busy;

    modport master (
        output fetch_req, pc_load, pc_target, rom_data,
        input  rom_en, rom_addr, Inst, Inst_Addr, fetch_done, busy
    );

    modport slave (
        input  fetch_req, pc_load, pc_target, rom_data,
        output rom_en, rom_addr, Inst, Inst_Addr, fetch_done, busy
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch stage: owns the PC and the instruction register and turns
// each fetch into a request/complete handshake against a synchronous ROM
// with ROM_LAT (1..3) cycles of read latency.
// Parameters:
//   ROM_LAT  - ROM read latency in cycles (1..3)
//   RESET_PC - PC value after reset
// Ports:
//   clk  - rising-edge clock
//   Rst  - asynchronous active-low reset
//   bus  - inst_fetch_unit_if.slave (handshake, redirect and ROM port)
// Optional feature: define FETCH_PREFETCH_EN to add a one-entry prefetch
// buffer that is filled in the background after every completed fetch and
// lets the next sequential fetch complete one cycle after its request.
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int unsigned ROM_LAT  = 1,
    parameter logic [5:0]  RESET_PC = 6'd0
) (
    input  logic             clk,
    input  logic             Rst,
    inst_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 32'd1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [5:0]  pc_q, pc_d;
    logic [5:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0] inst_q, inst_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        rom_en_q, rom_en_d;
    logic [5:0]  rom_addr_q, rom_addr_d;
    logic        pend_vld_q, pend_vld_d;
    logic [5:0]  pend_tgt_q, pend_tgt_d;

    logic        redirect_s;
    logic [5:0]  redir_tgt_s;
    logic        launch_s;
    logic [5:0]  launch_addr_s;

`ifdef FETCH_PREFETCH_EN
    logic        bg_q, bg_d;           // current ROM access is a background prefetch
    logic        req_lat_q, req_lat_d; // request arrived during a prefetch
    logic        pf_vld_q, pf_vld_d;
    logic [5:0]  pf_addr_q, pf_addr_d;
    logic [31:0] pf_data_q, pf_data_d;
    logic        launch_bg_s;
`endif

    // Next-state and next-register computation for the fetch FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        inst_d       = inst_q;
        done_d       = 1'b0;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        launch_s      = 1'b0;
        launch_addr_s = pc_q;
        // A same-cycle pc_load overrides an older pending redirect
        redirect_s  = bus.pc_load | pend_vld_q;
        redir_tgt_s = bus.pc_load ? bus.pc_target : pend_tgt_q;
`ifdef FETCH_PREFETCH_EN
        launch_bg_s = 1'b0;
        bg_d        = bg_q;
        pf_addr_d   = pf_addr_q;
        pf_data_d   = pf_data_q;
        if (bus.pc_load) begin
            pf_vld_d = 1'b0;
        end else begin
            pf_vld_d = pf_vld_q;
        end
        if ((state_q != IDLE) && bg_q && bus.fetch_req) begin
            req_lat_d = 1'b1;
        end else begin
            req_lat_d = req_lat_q;
        end
`endif
        // Redirects seen while busy are held until the fetch completes
        if ((state_q != IDLE) && bus.pc_load) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = bus.pc_target;
        end else begin
            pend_vld_d = pend_vld_q;
            pend_tgt_d = pend_tgt_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.pc_load) begin
                    pc_d = bus.pc_target;
                end else begin
                    pc_d = pc_q;
                end
                if (bus.fetch_req) begin
`ifdef FETCH_PREFETCH_EN
                    if (pf_vld_q && (pf_addr_q == pc_q) && !bus.pc_load) begin
                        inst_d        = pf_data_q;
                        done_d        = 1'b1;
                        pc_d          = pc_q + 6'd1;
                        pf_vld_d      = 1'b0;
                        launch_bg_s   = 1'b1;
                        launch_addr_s = pc_q + 6'd1;
                    end else begin
                        launch_s      = 1'b1;
                        launch_addr_s = bus.pc_load ? bus.pc_target : pc_q;
                    end
`else
                    launch_s      = 1'b1;
                    launch_addr_s = bus.pc_load ? bus.pc_target : pc_q;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (ROM_LAT > 32'd1) begin
                    state_d = WAIT;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d    = IDLE;
                pend_vld_d = 1'b0;
`ifdef FETCH_PREFETCH_EN
                if (bg_q) begin
                    if (redirect_s) begin
                        // Prefetched word is stale; restart at the new target if asked
                        pc_d = redir_tgt_s;
                        if (req_lat_q || bus.fetch_req) begin
                            launch_s      = 1'b1;
                            launch_addr_s = redir_tgt_s;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (req_lat_q || bus.fetch_req) begin
                        inst_d        = bus.rom_data;
                        done_d        = 1'b1;
                        pc_d          = fetch_addr_q + 6'd1;
                        launch_bg_s   = 1'b1;
                        launch_addr_s = fetch_addr_q + 6'd1;
                    end else begin
                        pf_data_d = bus.rom_data;
                        pf_addr_d = fetch_addr_q;
                        pf_vld_d  = 1'b1;
                    end
                end else begin
                    inst_d        = bus.rom_data;
                    done_d        = 1'b1;
                    pc_d          = redirect_s ? redir_tgt_s : (fetch_addr_q + 6'd1);
                    launch_bg_s   = 1'b1;
                    launch_addr_s = redirect_s ? redir_tgt_s : (fetch_addr_q + 6'd1);
                end
`else
                inst_d = bus.rom_data;
                done_d = 1'b1;
                pc_d   = redirect_s ? redir_tgt_s : (fetch_addr_q + 6'd1);
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Start a ROM access: one ISSUE cycle with the enable asserted
        if (launch_s) begin
            state_d      = ISSUE;
            rom_en_d     = 1'b1;
            rom_addr_d   = launch_addr_s;
            fetch_addr_d = launch_addr_s;
            cnt_d        = LAT_M1;
`ifdef FETCH_PREFETCH_EN
            bg_d         = 1'b0;
            req_lat_d    = 1'b0;
`endif
        end else begin
            rom_en_d = rom_en_d;
        end
`ifdef FETCH_PREFETCH_EN
        if (launch_bg_s) begin
            state_d      = ISSUE;
            rom_en_d     = 1'b1;
            rom_addr_d   = launch_addr_s;
            fetch_addr_d = launch_addr_s;
            cnt_d        = LAT_M1;
            bg_d         = 1'b1;
            req_lat_d    = 1'b0;
        end else begin
            bg_d = bg_d;
        end
`endif
        busy_d = (state_d != IDLE);
    end

    // Fetch FSM state, PC, instruction register and ROM port registers
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            pc_q         <= RESET_PC;
            fetch_addr_q <= 6'd0;
            inst_q       <= 32'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= 6'd0;
            pend_vld_q   <= 1'b0;
            pend_tgt_q   <= 6'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            inst_q       <= inst_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            pend_vld_q   <= pend_vld_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

`ifdef FETCH_PREFETCH_EN
    // Prefetch buffer and background-access bookkeeping
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            bg_q      <= 1'b0;
            req_lat_q <= 1'b0;
            pf_vld_q  <= 1'b0;
            pf_addr_q <= 6'd0;
            pf_data_q <= 32'd0;
        end else begin
            bg_q      <= bg_d;
            req_lat_q <= req_lat_d;
            pf_vld_q  <= pf_vld_d;
            pf_addr_q <= pf_addr_d;
            pf_data_q <= pf_data_d;
        end
    end
`endif

    assign bus.rom_en     = rom_en_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.Inst       = inst_q;
    assign bus.Inst_Addr  = pc_q;
    assign bus.fetch_done = done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit: one instance with ROM_LAT=1 and
// RESET_PC=0, one with ROM_LAT=3 and RESET_PC=8, each with its own ROM model.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic rst1_n;
    logic rst3_n;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   seen;
    int   last;
    logic [31:0] rom [64];
    logic [31:0] p0, p1;

    inst_fetch_unit_if b1 ();
    inst_fetch_unit_if b3 ();

    inst_fetch_unit #(.ROM_LAT(1), .RESET_PC(6'd0)) u_dut1 (.clk(clk), .Rst(rst1_n), .bus(b1));
    inst_fetch_unit #(.ROM_LAT(3), .RESET_PC(6'd8)) u_dut3 (.clk(clk), .Rst(rst3_n), .bus(b3));

    always #5 clk = ~clk;

    // One-cycle ROM; output is poisoned when not enabled
    always @(posedge clk) begin
        b1.rom_data <= b1.rom_en ? rom[b1.rom_addr] : 32'hDEAD_BEEF;
    end

    // Three-cycle ROM pipeline
    always @(posedge clk) begin
        p0          <= b3.rom_en ? rom[b3.rom_addr] : 32'hDEAD_BEEF;
        p1          <= p0;
        b3.rom_data <= p1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges from the request edge until fetch_done is seen (bounded)
    task automatic lat1(output int cnt);
        cnt = 0;
        while (b1.fetch_done !== 1'b1 && cnt < 12) begin
            tick();
            cnt++;
        end
    endtask

    task automatic lat3(output int cnt);
        cnt = 0;
        while (b3.fetch_done !== 1'b1 && cnt < 12) begin
            tick();
            cnt++;
        end
    endtask

    task automatic idle1();
        int c;
        c = 0;
        while (b1.busy !== 1'b0 && c < 20) begin
            tick();
            c++;
        end
        chk("idle1_timeout", 32'(c < 20), 32'd1);
    endtask

    task automatic idle3();
        int c;
        c = 0;
        while (b3.busy !== 1'b0 && c < 20) begin
            tick();
            c++;
        end
        chk("idle3_timeout", 32'(c < 20), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'hC0DE_0000 | 32'(i);
        end
        rom[0] = 32'hE3A01005;
        b1.fetch_req = 1'b0; b1.pc_load = 1'b0; b1.pc_target = 6'd0;
        b3.fetch_req = 1'b0; b3.pc_load = 1'b0; b3.pc_target = 6'd0;
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_inst", b1.Inst, 32'd0);
        chk("rst_pc", 32'(b1.Inst_Addr), 32'd0);
        chk("rst_done", 32'(b1.fetch_done), 32'd0);
        chk("rst_busy", 32'(b1.busy), 32'd0);
        chk("rst_rom_en", 32'(b1.rom_en), 32'd0);
        chk("rst_rom_addr", 32'(b1.rom_addr), 32'd0);
        chk("rst3_pc", 32'(b3.Inst_Addr), 32'd8);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        tick();

        // First fetch, ROM_LAT=1
        b1.fetch_req = 1'b1;
        tick();
        b1.fetch_req = 1'b0;
        chk("issue_en", 32'(b1.rom_en), 32'd1);
        chk("issue_addr", 32'(b1.rom_addr), 32'd0);
        chk("issue_busy", 32'(b1.busy), 32'd1);
        tick();
        chk("done_early", 32'(b1.fetch_done), 32'd0);
        chk("en_after_issue", 32'(b1.rom_en), 32'd0);
        tick();
        chk("done1", 32'(b1.fetch_done), 32'd1);
        chk("inst1", b1.Inst, 32'hE3A01005);
        chk("pc1", 32'(b1.Inst_Addr), 32'd1);
        tick();
        chk("done_pulse", 32'(b1.fetch_done), 32'd0);

`ifdef FETCH_PREFETCH_EN
        // Sequential fetch served from the prefetch buffer
        idle1();
        b1.fetch_req = 1'b1;
        tick();
        b1.fetch_req = 1'b0;
        chk("pf_done", 32'(b1.fetch_done), 32'd1);
        chk("pf_inst", b1.Inst, rom[1]);
        chk("pf_pc", 32'(b1.Inst_Addr), 32'd2);
        idle1();
        b1.pc_load = 1'b1;
        b1.pc_target = 6'd10;
        tick();
        b1.pc_load = 1'b0;
        b1.fetch_req = 1'b1;
        tick();
        b1.fetch_req = 1'b0;
        lat1(n);
        chk("pf_redir_lat", 32'(n), 32'd2);
        chk("pf_redir_inst", b1.Inst, rom[10]);
        chk("pf_redir_pc", 32'(b1.Inst_Addr), 32'd11);
`else
        // Four back-to-back fetches from address 0
        b1.fetch_req = 1'b1;
        b1.pc_load = 1'b1;
        b1.pc_target = 6'd0;
        seen = 0;
        last = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            b1.pc_load = 1'b0;
            if (c == 12) b1.fetch_req = 1'b0;
            if (b1.fetch_done === 1'b1) begin
                chk("b2b_inst", b1.Inst, rom[6'(seen)]);
                chk("b2b_gap", 32'(c - last), 32'd3);
                seen++;
                last = c;
            end
        end
        chk("b2b_count", 32'(seen), 32'd4);
        chk("b2b_pc", 32'(b1.Inst_Addr), 32'd4);
        chk("b2b_busy", 32'(b1.busy), 32'd0);

        // PC wrap 63 -> 0
        b1.pc_load = 1'b1;
        b1.pc_target = 6'd63;
        tick();
        b1.pc_load = 1'b0;
        chk("load_pc63", 32'(b1.Inst_Addr), 32'd63);
        b1.fetch_req = 1'b1;
        tick();
        b1.fetch_req = 1'b0;
        lat1(n);
        chk("wrap_lat", 32'(n), 32'd2);
        chk("wrap_inst", b1.Inst, rom[63]);
        chk("wrap_pc", 32'(b1.Inst_Addr), 32'd0);

        // Redirect together with the request
        b1.fetch_req = 1'b1;
        b1.pc_load = 1'b1;
        b1.pc_target = 6'd20;
        tick();
        b1.fetch_req = 1'b0;
        b1.pc_load = 1'b0;
        chk("redir_addr", 32'(b1.rom_addr), 32'd20);
        lat1(n);
        chk("redir_lat", 32'(n), 32'd2);
        chk("redir_inst", b1.Inst, rom[20]);
        chk("redir_pc", 32'(b1.Inst_Addr), 32'd21);
`endif

        // ROM_LAT=3 fetch from RESET_PC
        idle3();
        b3.fetch_req = 1'b1;
        tick();
        b3.fetch_req = 1'b0;
        lat3(n);
        chk("lat3_lat", 32'(n), 32'd4);
        chk("lat3_inst", b3.Inst, rom[8]);
        chk("lat3_pc", 32'(b3.Inst_Addr), 32'd9);

        // Redirect arriving during WAIT
        idle3();
        b3.fetch_req = 1'b1;
        b3.pc_load = 1'b1;
        b3.pc_target = 6'd9;
        tick();
        b3.fetch_req = 1'b0;
        b3.pc_load = 1'b0;
        chk("lat3_addr", 32'(b3.rom_addr), 32'd9);
        tick();
        chk("wait_busy", 32'(b3.busy), 32'd1);
        b3.pc_load = 1'b1;
        b3.pc_target = 6'd5;
        tick();
        b3.pc_load = 1'b0;
        lat3(n);
        chk("pend_lat", 32'(n), 32'd2);
        chk("pend_inst", b3.Inst, rom[9]);
        chk("pend_pc", 32'(b3.Inst_Addr), 32'd5);

        // Reset during WAIT abandons the fetch
        idle3();
        b3.fetch_req = 1'b1;
        b3.pc_load = 1'b1;
        b3.pc_target = 6'd30;
        tick();
        b3.fetch_req = 1'b0;
        b3.pc_load = 1'b0;
        tick();
        rst3_n = 1'b0;
        #1;
        chk("midrst_inst", b3.Inst, 32'd0);
        chk("midrst_pc", 32'(b3.Inst_Addr), 32'd8);
        chk("midrst_busy", 32'(b3.busy), 32'd0);
        tick();
        tick();
        rst3_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (b3.fetch_done === 1'b1) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        chk("midrst_inst_after", b3.Inst, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
